// File: rtl/kuz_pkg.sv
// rtl/kuz_pkg.sv - shared types, GF(2^8) constants and multiply for the Kuznyechik L^-1 datapath
// Contents:
//   kuz_byte_t / kuz_block_t : byte and 128-bit state types
//   GF_POLY                  : low byte of the field polynomial x^8+x^7+x^6+x+1
//   L_COEF[k]                : coefficient multiplying argument byte b_k of the linear function l
//   kuz_state_t              : FSM states of kuz_linv_iter
//   gf_mul(a,b)              : 8x8 field multiply with reduction
package kuz_pkg;

    typedef logic [7:0]   kuz_byte_t;
    typedef logic [127:0] kuz_block_t;

    localparam kuz_byte_t GF_POLY = 8'hC3;

    // L_COEF[15] pairs with b15, L_COEF[0] with b0.
    localparam logic [15:0][7:0] L_COEF = {
        8'd148, 8'd32,  8'd133, 8'd16,
        8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,
        8'd133, 8'd32,  8'd148, 8'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } kuz_state_t;

    // Shift-and-add multiply; the multiplicand is reduced each time it overflows bit 7.
    function automatic kuz_byte_t gf_mul(input kuz_byte_t a, input kuz_byte_t b);
        kuz_byte_t w_acc;
        kuz_byte_t w_a;
        w_acc = '0;
        w_a   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                w_acc = w_acc ^ w_a;
            end
            w_a = w_a[7] ? ({w_a[6:0], 1'b0} ^ GF_POLY) : {w_a[6:0], 1'b0};
        end
        return w_acc;
    endfunction

endpackage

// File: rtl/kuz_linv_step.sv
// rtl/kuz_linv_step.sv - one combinational R^-1 step of the Kuznyechik inverse linear transform
// Ports:
//   i_state  in  128  state a15..a0 (a15 = bits [127:120])
//   o_state  out 128  a14..a0 || l(a14,..,a0,a15)
module kuz_linv_step
    import kuz_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    kuz_byte_t w_new;

    // Argument b_k of l is a_(k-1) for k>=1 and the outgoing a15 for k=0.
    always_comb begin
        w_new = '0;
        w_new = w_new ^ gf_mul(i_state[127:120], L_COEF[0]);
        for (int k = 1; k < 16; k++) begin
            w_new = w_new ^ gf_mul(i_state[8*(k-1) +: 8], L_COEF[k]);
        end
    end

    assign o_state = {i_state[119:0], w_new};

endmodule

// File: rtl/kuz_linv_iter.sv
// rtl/kuz_linv_iter.sv - iterative Kuznyechik L^-1 (16 x R^-1) with valid/ready on both sides
// Parameter STEPS_PER_CYCLE (1,2,4,8,16): R^-1 steps unrolled per clock.
// Optional macro KUZ_LINV_BYPASS_EN adds in_bypass: the block goes straight to DONE unmodified.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake, in_data 128-bit state (a15 = [127:120])
//   in_bypass         (KUZ_LINV_BYPASS_EN only) pass in_data through untransformed
//   out_valid/out_ready output handshake, out_data = L^-1(in_data)
module kuz_linv_iter
    import kuz_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef KUZ_LINV_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4 &&
            STEPS_PER_CYCLE != 8 && STEPS_PER_CYCLE != 16) begin : g_bad_param
            $error("kuz_linv_iter: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP_INC = 5'(STEPS_PER_CYCLE);

    kuz_state_t r_state;
    logic [4:0] r_cnt;
    kuz_block_t r_work;
    logic       r_out_valid;
    kuz_block_t r_out_data;

    logic [STEPS_PER_CYCLE:0][127:0] w_chain;
    logic [4:0]                      w_cnt_next;
    logic                            w_in_ready;
    logic                            w_bypass;

`ifdef KUZ_LINV_BYPASS_EN
    assign w_bypass = in_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_chain[0] = r_work;

    generate
        for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
            kuz_linv_step u_step (
                .i_state (w_chain[g]),
                .o_state (w_chain[g+1])
            );
        end
    endgenerate

    assign w_cnt_next = r_cnt + STEP_INC;

    // DONE can accept the next block on the same edge that hands off the result.
    assign w_in_ready = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_state == ST_DONE && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                    // A load overrides the release above so back-to-back blocks have no bubble.
                    if (in_valid && w_in_ready) begin
                        if (w_bypass) begin
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_work      <= in_data;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_work <= w_chain[STEPS_PER_CYCLE];
                    r_cnt  <= w_cnt_next;
                    if (w_cnt_next == 5'd16) begin
                        r_out_data  <= w_chain[STEPS_PER_CYCLE];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
